// File: rtl/dh_pkg.sv
// Shared types and constants for the DH modular-exponentiation job scheduler.
package dh_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } dh_state_e;

  localparam int DH_W           = 100;
  localparam int DH_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/dh_rr_arbiter2.sv
// Two-way round-robin arbiter; the served requester drops to low priority on update.
module dh_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       valid_o,
  output logic       grant_o
);

  logic prio_q, prio_d;

  always_ff @(posedge clk) begin
    if (!rst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end

  always_comb begin
    prio_d = prio_q;
    if (update_i) prio_d = ~served_i;
  end

  // The prioritised requester wins if it asks; otherwise the other one does.
  always_comb begin
    valid_o = |req_i;
    grant_o = prio_q;
    if (!req_i[prio_q]) grant_o = ~prio_q;
  end

endmodule

// File: rtl/dh_modexp_scheduler.sv
// Arbitrates two requesters onto one modexp engine and returns results with an ack pulse.
// Optional watchdog enabled by defining DH_MODEXP_SCHED_TIMEOUT_EN.
module dh_modexp_scheduler
  import dh_pkg::*;
#(
  parameter int W           = DH_W,
  parameter int TIMEOUT_CYC = DH_TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] base0,
  input  logic [W-1:0] base1,
  input  logic [W:0]   exp0,
  input  logic [W:0]   exp1,
  input  logic [W-1:0] prime0,
  input  logic [W-1:0] prime1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] result,
  output logic         err,
  output logic         eng_start,
  output logic [W-1:0] eng_base,
  output logic [W:0]   eng_exp,
  output logic [W-1:0] eng_prime,
  input  logic         eng_busy,
  input  logic [W-1:0] eng_result
);

  dh_state_e    state_q, state_d;
  logic         grant_q, grant_d;
  logic [W-1:0] engBase_q, engBase_d;
  logic [W:0]   engExp_q, engExp_d;
  logic [W-1:0] engPrime_q, engPrime_d;
  logic [W-1:0] result_q, result_d;
  logic         arbValid, arbGrant;
  logic         busyHit, doneHit, timeout;

  dh_rr_arbiter2 uArb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({req1, req0}),
    .update_i (state_q == RESP),
    .served_i (grant_q),
    .valid_o  (arbValid),
    .grant_o  (arbGrant)
  );

  assign busyHit = (state_q == WAIT_BUSY) && eng_busy;
  assign doneHit = (state_q == WAIT_DONE) && !eng_busy;

`ifdef DH_MODEXP_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Counter restarts whenever the FSM changes state, so each wait state gets a full budget.
  assign timeout = ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) &&
                   (cnt_q == TO_LAST) && !busyHit && !doneHit;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)                                cnt_d = '0;
    else if ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) cnt_d = cnt_q + 1'b1;
    err_d = err_q;
    if (doneHit)      err_d = 1'b0;
    else if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (arbValid) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (busyHit) state_d = WAIT_DONE;
                 else if (timeout) state_d = RESP;
      WAIT_DONE: if (doneHit || timeout) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    eng_start = (state_q == LAUNCH);
    ack0      = (state_q == RESP) && !grant_q;
    ack1      = (state_q == RESP) && grant_q;
  end

  // Operands are captured only at grant so the requester may change its inputs afterwards.
  always_comb begin
    grant_d    = grant_q;
    engBase_d  = engBase_q;
    engExp_d   = engExp_q;
    engPrime_d = engPrime_q;
    result_d   = result_q;
    if ((state_q == IDLE) && arbValid) begin
      grant_d    = arbGrant;
      engBase_d  = arbGrant ? base1  : base0;
      engExp_d   = arbGrant ? exp1   : exp0;
      engPrime_d = arbGrant ? prime1 : prime0;
    end
    if (doneHit)      result_d = eng_result;
    else if (timeout) result_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q    <= 1'b0;
      engBase_q  <= '0;
      engExp_q   <= '0;
      engPrime_q <= '0;
      result_q   <= '0;
    end else begin
      grant_q    <= grant_d;
      engBase_q  <= engBase_d;
      engExp_q   <= engExp_d;
      engPrime_q <= engPrime_d;
      result_q   <= result_d;
    end
  end

  assign eng_base  = engBase_q;
  assign eng_exp   = engExp_q;
  assign eng_prime = engPrime_q;
  assign result    = result_q;

endmodule

// File: tb/tb_dh_modexp_scheduler.sv
// Self-checking bench for dh_modexp_scheduler with a behavioural engine stub and scoreboard.
module tb_dh_modexp_scheduler;

  localparam int W = 100;
`ifdef DH_MODEXP_SCHED_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 65535;
`endif

  logic         clk = 1'b0, rst = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] base0 = '0, base1 = '0, prime0 = '0, prime1 = '0;
  logic [W:0]   exp0 = '0, exp1 = '0;
  logic         ack0, ack1, err, eng_start, eng_busy;
  logic [W-1:0] result, eng_base, eng_prime, eng_result;
  logic [W:0]   eng_exp;

  int compared = 0, mismatched = 0, dualAcks = 0;

  always #5 clk = ~clk;

  dh_modexp_scheduler #(.W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .base0(base0), .base1(base1), .exp0(exp0), .exp1(exp1),
    .prime0(prime0), .prime1(prime1), .ack0(ack0), .ack1(ack1),
    .result(result), .err(err), .eng_start(eng_start), .eng_base(eng_base),
    .eng_exp(eng_exp), .eng_prime(eng_prime), .eng_busy(eng_busy),
    .eng_result(eng_result)
  );

  function automatic longint refModExp(input longint b, input longint e, input longint p);
    longint r;
    if (p <= 0) return 0;
    r = 1 % p;
    for (longint i = 0; i < e; i++) r = (r * (b % p)) % p;
    return r;
  endfunction

  // Engine stub: busy rises engDelay cycles after the start edge and lasts engLen cycles.
  int           engTick = 0, engDelay = 2, engLen = 20;
  bit           engNever = 1'b0, idleBusy = 1'b0;
  logic         startPrev = 1'b0;
  logic [W-1:0] engGood = '0;
  logic         modelBusy;

  assign modelBusy  = (engTick > 0) && (engTick >= engDelay) && (engTick < engDelay + engLen);
  assign eng_busy   = modelBusy | idleBusy;
  assign eng_result = modelBusy ? W'(128'hDEAD_BEEF) : engGood;

  always @(posedge clk) begin
    startPrev <= eng_start;
    if (eng_start && !startPrev && !engNever) begin
      engTick <= 1;
      engGood <= W'(refModExp(longint'(eng_base[31:0]), longint'(eng_exp[31:0]),
                              longint'(eng_prime[31:0])));
    end else if (engTick > 0) begin
      if (engTick >= engDelay + engLen) engTick <= 0;
      else                              engTick <= engTick + 1;
    end
  end

  always @(negedge clk) if (ack0 && ack1) dualAcks++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input longint b, input longint e, input longint p);
    if (id == 0) begin
      base0 = W'(b); exp0 = (W+1)'(e); prime0 = W'(p); req0 = 1'b1;
    end else begin
      base1 = W'(b); exp1 = (W+1)'(e); prime1 = W'(p); req1 = 1'b1;
    end
  endtask

  task automatic dropReq(input int id);
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
  endtask

  task automatic waitAck(output int id, output int n);
    id = -1;
    n  = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (ack0) begin id = 0; break; end
      if (ack1) begin id = 1; break; end
    end
    if (id < 0) checkOutput("ackWithinBudget", 0, 1);
  endtask

  task automatic doReset();
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (engTick == 0) break;
      tick();
    end
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    int     reqId;
    longint base, expo, prime;
    int     delay, len;
    longint expResult;
    int     expLatency;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int     id, n, lastServed, expId;
    bit     stableOk, pend[2];
    int     altExp[4];
    longint opB[2], opE[2], opP[2];

    vecs[0] = '{0, 4, 13, 497, 2, 20, 445, 25};
    vecs[1] = '{1, 2, 10, 1000, 1, 1, 24, 5};
    vecs[2] = '{0, 3, 0, 7, 3, 4, 1, 10};
    vecs[3] = '{1, 5, 3, 13, 1, 6, 8, 10};
    vecs[4] = '{0, 7, 2, 10, 4, 2, 9, 9};
    altExp  = '{1, 0, 1, 0};

    rst = 1'b0;
    tick();
    tick();
    checkOutput("rstAck0", ack0, 0);
    checkOutput("rstAck1", ack1, 0);
    checkOutput("rstStart", eng_start, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstResult", result, 0);
    checkOutput("rstEngBase", eng_base, 0);
    checkOutput("rstEngExp", eng_exp, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      engDelay = vecs[i].delay;
      engLen   = vecs[i].len;
      applyStimulus(vecs[i].reqId, vecs[i].base, vecs[i].expo, vecs[i].prime);
      waitAck(id, n);
      checkOutput("vecAckId", id, vecs[i].reqId);
      checkOutput("vecLatency", n + 1, vecs[i].expLatency);
      checkOutput("vecResult", result, vecs[i].expResult);
      checkOutput("vecErr", err, 0);
      dropReq(vecs[i].reqId);
      tick();
      tick();
      tick();
      checkOutput("resultHold", result, vecs[i].expResult);
    end

    // Simultaneous requests right after reset: requester 0 first.
    doReset();
    engDelay = 1; engLen = 3;
    applyStimulus(0, 6, 5, 101);
    applyStimulus(1, 9, 4, 97);
    waitAck(id, n);
    checkOutput("simulFirst", id, 0);
    checkOutput("simulFirstRes", result, refModExp(6, 5, 101));
    dropReq(0);
    waitAck(id, n);
    checkOutput("simulSecond", id, 1);
    checkOutput("simulSecondRes", result, refModExp(9, 4, 97));
    dropReq(1);

    // req1 held throughout, req0 re-requests from the first ack onward.
    doReset();
    applyStimulus(1, 3, 3, 11);
    for (int k = 0; k < 4; k++) begin
      waitAck(id, n);
      checkOutput("altGrant", id, altExp[k]);
      if (k == 0) applyStimulus(0, 2, 5, 31);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();

    // Operand change after grant must not disturb the running job.
    engDelay = 2; engLen = 20;
    applyStimulus(0, 4, 13, 497);
    tick();
    base0 = W'(7);
    stableOk = 1'b1;
    id = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (eng_base != W'(4)) stableOk = 1'b0;
      if (ack0) begin id = 0; break; end
    end
    checkOutput("engBaseStable", stableOk, 1);
    checkOutput("stableAck", id, 0);
    checkOutput("stableResult", result, 445);
    dropReq(0);
    tick();

    // Engine busy while idle must not block a grant.
    idleBusy = 1'b1;
    engDelay = 1; engLen = 2;
    applyStimulus(0, 5, 7, 23);
    tick();
    checkOutput("startDespiteBusy", eng_start, 1);
    idleBusy = 1'b0;
    waitAck(id, n);
    checkOutput("idleBusyAck", id, 0);
    checkOutput("idleBusyRes", result, refModExp(5, 7, 23));
    dropReq(0);
    tick();

    // Reset during WAIT_DONE abandons the job silently.
    engDelay = 2; engLen = 20;
    applyStimulus(0, 4, 13, 497);
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b0;
    tick();
    checkOutput("midRstAck", ack0 | ack1, 0);
    checkOutput("midRstStart", eng_start, 0);
    checkOutput("midRstResult", result, 0);
    checkOutput("midRstErr", err, 0);
    checkOutput("midRstBase", eng_base, 0);
    rst = 1'b1;
    req0 = 1'b0;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (ack0 || ack1) n++;
    end
    checkOutput("midRstNoAck", n, 0);
    applyStimulus(0, 4, 13, 497);
    waitAck(id, n);
    checkOutput("postRstAck", id, 0);
    checkOutput("postRstRes", result, 445);
    dropReq(0);
    tick();

`ifdef DH_MODEXP_SCHED_TIMEOUT_EN
    engNever = 1'b1;
    applyStimulus(0, 4, 13, 497);
    waitAck(id, n);
    checkOutput("toAck", id, 0);
    checkOutput("toLatency", n + 1, 53);
    checkOutput("toErr", err, 1);
    checkOutput("toResult", result, 0);
    dropReq(0);
    tick();
    engNever = 1'b0;
    engDelay = 1; engLen = 2;
    applyStimulus(0, 3, 4, 7);
    waitAck(id, n);
    checkOutput("afterToAck", id, 0);
    checkOutput("afterToErr", err, 0);
    checkOutput("afterToRes", result, refModExp(3, 4, 7));
    dropReq(0);
    tick();
`endif

    // Randomised traffic against a round-robin scoreboard.
    doReset();
    lastServed = 1;
    pend = '{1'b0, 1'b0};
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
          pend[r] = 1'b1;
          opB[r]  = longint'($urandom_range(0, 65535));
          opE[r]  = longint'($urandom_range(0, 40));
          opP[r]  = longint'($urandom_range(2, 65535));
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        opB[0]  = longint'($urandom_range(0, 65535));
        opE[0]  = longint'($urandom_range(0, 40));
        opP[0]  = longint'($urandom_range(2, 65535));
      end
      for (int r = 0; r < 2; r++) if (pend[r]) applyStimulus(r, opB[r], opE[r], opP[r]);
      engDelay = int'($urandom_range(1, 3));
      engLen   = int'($urandom_range(1, 8));
      expId    = (pend[0] && pend[1]) ? 1 - lastServed : (pend[0] ? 0 : 1);
      waitAck(id, n);
      checkOutput("rndGrant", id, expId);
      checkOutput("rndResult", result, refModExp(opB[expId], opE[expId], opP[expId]));
      checkOutput("rndErr", err, 0);
      if (id < 0) break;
      dropReq(id);
      pend[id]   = 1'b0;
      lastServed = id;
    end

    checkOutput("noDualAck", dualAcks, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
